// File: rtl/axis_inct_m2s_ordered.sv
// axis_inct_m2s_ordered
// Re-merges the frames returned by NUM parallel workers into one AXI-stream,
// in the order the upstream dispatcher handed them out. The dispatcher pushes
// each dispatched channel index into a small order queue. This block forwards
// whole frames from the channel named at the queue head, one frame at a time.
//
// Ports:
//   clock, rst       single clock; synchronous active-high reset
//   order_wr/addr    push one channel index into the order queue
//   order_full/empty registered queue flags
//   order_count      registered queue occupancy
//   order_ovf        sticky: push attempted while full (cleared by rst only)
//   s_t*             NUM slave channels; channel k data at [k*DSIZE +: DSIZE]
//   m_t*             merged master stream
//
// An index >= NUM pushed into the queue is kept as-is. That frame is never
// forwarded and blocks the queue; this is an integration error upstream.
module axis_inct_m2s_ordered #(
  parameter  int NUM   = 8,
  parameter  int DSIZE = 8,
  parameter  int DEPTH = 4,
  localparam int NSIZE = $clog2(NUM),
  localparam int CSIZE = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   order_wr,
  input  logic [NSIZE-1:0]       order_addr,
  output logic                   order_full,
  output logic                   order_empty,
  output logic [CSIZE-1:0]       order_count,
  output logic                   order_ovf,
  input  logic [NUM-1:0]         s_tvalid,
  input  logic [NUM*DSIZE-1:0]   s_tdata,
  input  logic [NUM-1:0]         s_tlast,
  output logic [NUM-1:0]         s_tready,
  output logic                   m_tvalid,
  output logic [DSIZE-1:0]       m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready
);

  localparam int PSIZE = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_e;

  state_e           state_q;
  logic [NSIZE-1:0] cur_ch_q;
  logic [NSIZE-1:0] mem_q [DEPTH];
  logic [PSIZE-1:0] wr_ptr_q;
  logic [PSIZE-1:0] rd_ptr_q;
  logic [CSIZE-1:0] count_q;
  logic [CSIZE-1:0] count_d;
  logic             full_q;
  logic             empty_q;
  logic             ovf_q;

  logic             push_s;
  logic             pop_s;
  logic             active_s;
  logic             ch_ok_s;
  logic             frame_end_s;

  // Wrap-around pointer increment; DEPTH need not be a power of two.
  function automatic logic [PSIZE-1:0] ptr_inc(input logic [PSIZE-1:0] p);
    if (p == PSIZE'(DEPTH - 1)) begin
      return {PSIZE{1'b0}};
    end else begin
      return p + {{(PSIZE-1){1'b0}}, 1'b1};
    end
  endfunction

  assign active_s = (state_q == S_ACTIVE);
  // Guards against an out-of-range index stored in the queue.
  assign ch_ok_s  = (int'(cur_ch_q) < NUM);

  // Master/slave mux. s_tready depends only on m_tready and the selected
  // channel, never on m_tvalid.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = s_tdata[DSIZE-1:0];
    m_tlast  = s_tlast[0];
    s_tready = {NUM{1'b0}};
    if (active_s && ch_ok_s) begin
      m_tvalid           = s_tvalid[cur_ch_q];
      m_tdata            = s_tdata[cur_ch_q*DSIZE +: DSIZE];
      m_tlast            = s_tlast[cur_ch_q];
      s_tready[cur_ch_q] = m_tready;
    end else begin
      m_tvalid = 1'b0;
    end
  end

  assign frame_end_s = m_tvalid && m_tready && m_tlast;
  // Full check uses the registered flag: a push while full is dropped even
  // when a pop happens in the same cycle.
  assign push_s      = order_wr && !full_q;
  // Pop when idle, or at the last beat of a frame so the next frame follows
  // with no bubble.
  assign pop_s       = !empty_q && (!active_s || frame_end_s);

  // Next queue occupancy.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CSIZE'(1);
      2'b01:   count_d = count_q - CSIZE'(1);
      default: count_d = count_q;
    endcase
  end

  // Order queue storage (contents need no reset; pointers define validity).
  always_ff @(posedge clock) begin
    if (push_s && !rst) begin
      mem_q[wr_ptr_q] <= order_addr;
    end
  end

  // Queue pointers, flags and the frame-selection state machine.
  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_q <= {PSIZE{1'b0}};
      rd_ptr_q <= {PSIZE{1'b0}};
      count_q  <= {CSIZE{1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      cur_ch_q <= {NSIZE{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
      full_q  <= (count_d == CSIZE'(DEPTH));
      empty_q <= (count_d == {CSIZE{1'b0}});
      if (order_wr && full_q) begin
        ovf_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (pop_s) begin
            cur_ch_q <= mem_q[rd_ptr_q];
            state_q  <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (frame_end_s) begin
            if (pop_s) begin
              cur_ch_q <= mem_q[rd_ptr_q];
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign order_full  = full_q;
  assign order_empty = empty_q;
  assign order_count = count_q;
  assign order_ovf   = ovf_q;

endmodule

// File: tb/tb_axis_inct_m2s_ordered.sv
// Directed bench for axis_inct_m2s_ordered: per-channel source buffers feed
// the slave channels, and every master beat is compared against an expected
// queue built in push order.
module tb_axis_inct_m2s_ordered;
  localparam int NUM   = 8;
  localparam int DSIZE = 8;
  localparam int DEPTH = 4;
  localparam int NSIZE = 3;
  localparam int CSIZE = 3;
  localparam int BUFSZ = 1024;

  logic                 clock = 1'b0;
  logic                 rst;
  logic                 order_wr;
  logic [NSIZE-1:0]     order_addr;
  logic                 order_full;
  logic                 order_empty;
  logic [CSIZE-1:0]     order_count;
  logic                 order_ovf;
  logic [NUM-1:0]       s_tvalid;
  logic [NUM*DSIZE-1:0] s_tdata;
  logic [NUM-1:0]       s_tlast;
  logic [NUM-1:0]       s_tready;
  logic                 m_tvalid;
  logic [DSIZE-1:0]     m_tdata;
  logic                 m_tlast;
  logic                 m_tready;

  always #5 clock = ~clock;

  axis_inct_m2s_ordered #(.NUM(NUM), .DSIZE(DSIZE), .DEPTH(DEPTH)) dut (
    .clock(clock), .rst(rst),
    .order_wr(order_wr), .order_addr(order_addr),
    .order_full(order_full), .order_empty(order_empty),
    .order_count(order_count), .order_ovf(order_ovf),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int first_cyc, last_cyc, nbeats;
  bit drv_en, gaps_en, rdy_rand, sb_en;
  logic [DSIZE:0] chbuf [NUM][BUFSZ];
  int head [NUM];
  int tail [NUM];
  logic [DSIZE:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: sample handshakes at the negedge, then update sources after the edge.
  task automatic step();
    logic [NUM-1:0] hs;
    logic           mhs;
    logic [DSIZE:0] mbeat;
    @(negedge clock);
    hs    = s_tvalid & s_tready;
    mhs   = m_tvalid & m_tready;
    mbeat = {m_tlast, m_tdata};
    @(posedge clock);
    #1;
    cyc++;
    order_wr = 1'b0;
    if (sb_en && mhs) begin
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      nbeats++;
      if (exp_q.size() > 0) check("beat", 32'(mbeat), 32'(exp_q.pop_front()));
      else check("beat_extra", {23'd0, 1'b1, mbeat}, 32'd0);
    end
    if (drv_en) begin
      for (int k = 0; k < NUM; k++) begin
        if (hs[k]) head[k]++;
        if (s_tvalid[k] && !hs[k]) begin
          s_tvalid[k] = 1'b1;
        end else if (head[k] < tail[k] && (!gaps_en || $urandom_range(0, 2) != 0)) begin
          s_tvalid[k] = 1'b1;
          {s_tlast[k], s_tdata[k*DSIZE +: DSIZE]} = chbuf[k][head[k]];
        end else begin
          s_tvalid[k] = 1'b0;
        end
      end
      if (rdy_rand) m_tready = 1'($urandom_range(0, 1));
    end
    #1;
  endtask

  task automatic push_ch(input int ch);
    order_wr   = 1'b1;
    order_addr = NSIZE'(ch);
    step();
  endtask

  task automatic add_frame(input int ch, input int n, input int base, input bit rnd);
    logic [DSIZE:0] b;
    for (int i = 0; i < n; i++) begin
      b[DSIZE-1:0] = rnd ? DSIZE'($urandom_range(0, 255)) : DSIZE'(base + i);
      b[DSIZE]     = (i == n - 1);
      chbuf[ch][tail[ch]] = b;
      tail[ch]++;
      exp_q.push_back(b);
    end
  endtask

  task automatic clear_sources();
    drv_en = 1'b0; sb_en = 1'b0; gaps_en = 1'b0; rdy_rand = 1'b0;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b0;
    for (int k = 0; k < NUM; k++) begin head[k] = 0; tail[k] = 0; end
    exp_q.delete();
    first_cyc = -1; last_cyc = -1; nbeats = 0;
  endtask

  task automatic clean();
    clear_sources();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin step(); n++; end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int frames, n, ch, len;
    order_wr = 1'b0; order_addr = '0;
    clear_sources();

    // Reset with every source valid and the sink ready.
    rst = 1'b1; s_tvalid = '1; m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      check("rst_s_tready", 32'(s_tready), 32'd0);
      check("rst_empty", 32'(order_empty), 32'd1);
      check("rst_count", 32'(order_count), 32'd0);
    end
    rst = 1'b0;
    step();
    check("idle_m_tvalid", 32'(m_tvalid), 32'd0);
    check("idle_s_tready", 32'(s_tready), 32'd0);
    check("idle_full", 32'(order_full), 32'd0);
    check("idle_ovf", 32'(order_ovf), 32'd0);

    // Ordered merge of three concurrent frames, dispatched 2,0,1.
    clean();
    for (int k = 0; k < 3; k++) begin
      for (int b = 0; b < 3; b++) begin
        chbuf[k][b] = {b == 2, DSIZE'(k * 16 + b)};
      end
      tail[k] = 3;
    end
    exp_q = '{9'h020, 9'h021, 9'h122, 9'h000, 9'h001, 9'h102, 9'h010, 9'h011, 9'h112};
    drv_en = 1'b1; sb_en = 1'b1; m_tready = 1'b1;
    push_ch(2); push_ch(0); push_ch(1);
    drain("order_drain", 40);
    check("order_nbeats", 32'(nbeats), 32'd9);
    check("order_no_bubble", 32'(last_cyc - first_cyc), 32'd8);
    check("order_count_end", 32'(order_count), 32'd0);
    check("order_empty_end", 32'(order_empty), 32'd1);

    // Selected channel 5 stalls; channel 3 must be held off.
    clean();
    chbuf[3][0] = {1'b0, 8'h30}; chbuf[3][1] = {1'b1, 8'h31}; tail[3] = 2;
    exp_q = '{9'h155, 9'h030, 9'h131};
    drv_en = 1'b1; sb_en = 1'b1; m_tready = 1'b1;
    push_ch(5); push_ch(3);
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_m_tvalid", 32'(m_tvalid), 32'd0);
      check("hold_s_tready3", 32'(s_tready[3]), 32'd0);
    end
    check("hold_ch3_head", 32'(head[3]), 32'd0);
    chbuf[5][0] = {1'b1, 8'h55}; tail[5] = 1;
    drain("hold_drain", 20);
    check("hold_ch3_done", 32'(head[3]), 32'd2);

    // Overflow: channel 7 never delivers, so the queue fills without pops.
    clean();
    push_ch(7);
    step();
    for (int i = 0; i < 4; i++) push_ch(i);
    check("ovf_full", 32'(order_full), 32'd1);
    check("ovf_count", 32'(order_count), 32'd4);
    check("ovf_before", 32'(order_ovf), 32'd0);
    push_ch(4);
    check("ovf_set", 32'(order_ovf), 32'd1);
    check("ovf_count_kept", 32'(order_count), 32'd4);
    step(); step();
    check("ovf_sticky", 32'(order_ovf), 32'd1);
    clean();
    check("ovf_cleared", 32'(order_ovf), 32'd0);
    check("ovf_rst_empty", 32'(order_empty), 32'd1);

    // Reset in the middle of a 4-beat frame, then a fresh frame.
    clean();
    add_frame(6, 4, 8'h60, 1'b0);
    drv_en = 1'b1; sb_en = 1'b1; m_tready = 1'b1;
    push_ch(6);
    n = 0;
    while (nbeats < 1 && n < 10) begin step(); n++; end
    check("mid_first_beat", 32'(nbeats), 32'd1);
    sb_en = 1'b0;
    rst = 1'b1;
    step();
    check("mid_m_tvalid", 32'(m_tvalid), 32'd0);
    check("mid_s_tready", 32'(s_tready), 32'd0);
    check("mid_empty", 32'(order_empty), 32'd1);
    check("mid_ovf", 32'(order_ovf), 32'd0);
    rst = 1'b0;
    clear_sources();
    step();
    add_frame(1, 2, 8'h70, 1'b0);
    drv_en = 1'b1; sb_en = 1'b1; m_tready = 1'b1;
    push_ch(1);
    drain("mid_fresh_drain", 20);

    // Random frames with source gaps and sink backpressure.
    clean();
    drv_en = 1'b1; gaps_en = 1'b1; rdy_rand = 1'b1; sb_en = 1'b1;
    frames = 0; n = 0;
    while ((frames < 40 || exp_q.size() != 0) && n < 20000) begin
      if (frames < 40 && !order_full && $urandom_range(0, 1) == 1) begin
        ch  = $urandom_range(0, NUM - 1);
        len = $urandom_range(1, 16);
        add_frame(ch, len, 0, 1'b1);
        order_wr = 1'b1;
        order_addr = NSIZE'(ch);
        frames++;
      end
      step();
      n++;
    end
    check("rand_frames", 32'(frames), 32'd40);
    check("rand_drain", 32'(exp_q.size()), 32'd0);
    check("rand_ovf", 32'(order_ovf), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
